// File: rtl/sched_pkg.sv
// Shared types and control-word layout for the schedule sequencer.
package sched_pkg;

  localparam int unsigned SELW  = 4;
  localparam int unsigned NREG  = 16;
  localparam int unsigned DEPTH = 16;

  localparam int unsigned ALU_OP_W = 1;
  localparam int unsigned MUL_OP_W = 1;
  localparam int unsigned LOG_OP_W = 2;

  // Field LSB offsets, packed LSB first
  localparam int unsigned ALU_SEL1_LSB  = 0;
  localparam int unsigned ALU_SEL2_LSB  = SELW;
  localparam int unsigned ALU_OP_LSB    = 2 * SELW;
  localparam int unsigned MUL_SEL1_LSB  = 2 * SELW + 1;
  localparam int unsigned MUL_SEL2_LSB  = 3 * SELW + 1;
  localparam int unsigned MUL_OP_LSB    = 4 * SELW + 1;
  localparam int unsigned LOG_SEL1_LSB  = 4 * SELW + 2;
  localparam int unsigned LOG_SEL2_LSB  = 5 * SELW + 2;
  localparam int unsigned LOG_OP_LSB    = 6 * SELW + 2;
  localparam int unsigned REG_EN_LSB    = 6 * SELW + 4;
  localparam int unsigned RESULT_EN_LSB = REG_EN_LSB + NREG;
  localparam int unsigned LAST_LSB      = RESULT_EN_LSB + 1;
  localparam int unsigned CW_W          = 6 * SELW + 4 + NREG + 2;

  function automatic int unsigned cw_width(input int unsigned selw, input int unsigned nreg);
    return 6 * selw + 4 + nreg + 2;
  endfunction

  typedef struct packed {
    logic                last;
    logic                result_en;
    logic [NREG-1:0]     reg_en;
    logic [LOG_OP_W-1:0] log_op;
    logic [SELW-1:0]     log_sel2;
    logic [SELW-1:0]     log_sel1;
    logic [MUL_OP_W-1:0] mul_op;
    logic [SELW-1:0]     mul_sel2;
    logic [SELW-1:0]     mul_sel1;
    logic [ALU_OP_W-1:0] alu_op;
    logic [SELW-1:0]     alu_sel2;
    logic [SELW-1:0]     alu_sel1;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/sched_cw_mem.sv
// Control-word table: flop array with async clear, one write port, one async read port.
module sched_cw_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 46,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sched_seq_ctrl.sv
// Programmable schedule sequencer: replays a loaded control-word table one word per cycle.
// Optional SCHED_STALL_EN adds a stall input that pauses the pc and masks register enables.
module sched_seq_ctrl
  import sched_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NREG  = 16,
  parameter int unsigned SELW  = 4,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = cw_width(SELW, NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef SCHED_STALL_EN
  input  logic            stall,
`endif
  output logic            op_ready,
  output logic            busy,
  output logic            done_next,
  output logic            result_en,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [CW-1:0]   cfg_wdata,
  output logic            cfg_err,
  output logic [SELW-1:0] alu_sel1,
  output logic [SELW-1:0] alu_sel2,
  output logic [SELW-1:0] mul_sel1,
  output logic [SELW-1:0] mul_sel2,
  output logic [SELW-1:0] log_sel1,
  output logic [SELW-1:0] log_sel2,
  output logic            alu_op,
  output logic            mul_op,
  output logic [1:0]      log_op,
  output logic [NREG-1:0] reg_en
);

  localparam int unsigned O_ALU_SEL2 = SELW;
  localparam int unsigned O_ALU_OP   = 2 * SELW;
  localparam int unsigned O_MUL_SEL1 = 2 * SELW + 1;
  localparam int unsigned O_MUL_SEL2 = 3 * SELW + 1;
  localparam int unsigned O_MUL_OP   = 4 * SELW + 1;
  localparam int unsigned O_LOG_SEL1 = 4 * SELW + 2;
  localparam int unsigned O_LOG_SEL2 = 5 * SELW + 2;
  localparam int unsigned O_LOG_OP   = 6 * SELW + 2;
  localparam int unsigned O_REG_EN   = 6 * SELW + 4;
  localparam int unsigned O_RESULT   = O_REG_EN + NREG;
  localparam int unsigned O_LAST     = O_RESULT + 1;

  state_t        state;
  logic [AW-1:0] pc;
  logic [CW-1:0] word;
  logic          stall_i;
  logic          tbl_we;

`ifdef SCHED_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign tbl_we = cfg_we && (state == S_IDLE);

  sched_cw_mem #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (pc),
    .rdata (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end
        S_RUN: begin
          // exit is only evaluated on cycles where the word is actually consumed
          if (!stall_i) begin
            if (word[O_LAST] || (pc == AW'(DEPTH - 1))) begin
              state <= S_DONE;
              pc    <= '0;
            end else begin
              pc <= pc + AW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign op_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign done_next = (state == S_DONE);

  always_comb begin
    alu_sel1  = '0;
    alu_sel2  = '0;
    mul_sel1  = '0;
    mul_sel2  = '0;
    log_sel1  = '0;
    log_sel2  = '0;
    alu_op    = 1'b0;
    mul_op    = 1'b0;
    log_op    = '0;
    reg_en    = '0;
    result_en = 1'b0;
    if (state == S_RUN) begin
      alu_sel1 = word[0 +: SELW];
      alu_sel2 = word[O_ALU_SEL2 +: SELW];
      alu_op   = word[O_ALU_OP];
      mul_sel1 = word[O_MUL_SEL1 +: SELW];
      mul_sel2 = word[O_MUL_SEL2 +: SELW];
      mul_op   = word[O_MUL_OP];
      log_sel1 = word[O_LOG_SEL1 +: SELW];
      log_sel2 = word[O_LOG_SEL2 +: SELW];
      log_op   = word[O_LOG_OP +: 2];
      if (!stall_i) begin
        reg_en    = word[O_REG_EN +: NREG];
        result_en = word[O_RESULT];
      end
    end
  end

endmodule

// File: tb/tb_sched_seq_ctrl.sv
// Directed bench for sched_seq_ctrl; stall scenario is compiled in with SCHED_STALL_EN.
module tb_sched_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
`ifdef SCHED_STALL_EN
  logic        stall;
`endif
  logic        op_ready, busy, done_next, result_en, cfg_err;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [45:0] cfg_wdata;
  logic [3:0]  alu_sel1, alu_sel2, mul_sel1, mul_sel2, log_sel1, log_sel2;
  logic        alu_op, mul_op;
  logic [1:0]  log_op;
  logic [15:0] reg_en;

  logic [44:0] fields;
  logic [2:0]  status;
  logic [45:0] w [4];
  logic [45:0] wbad, w0n;
  int          n_vec = 0;
  int          n_err = 0;

  sched_seq_ctrl #(
    .DEPTH (16),
    .NREG  (16),
    .SELW  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SCHED_STALL_EN
    .stall     (stall),
`endif
    .op_ready  (op_ready),
    .busy      (busy),
    .done_next (done_next),
    .result_en (result_en),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .alu_sel1  (alu_sel1),
    .alu_sel2  (alu_sel2),
    .mul_sel1  (mul_sel1),
    .mul_sel2  (mul_sel2),
    .log_sel1  (log_sel1),
    .log_sel2  (log_sel2),
    .alu_op    (alu_op),
    .mul_op    (mul_op),
    .log_op    (log_op),
    .reg_en    (reg_en)
  );

  assign fields = {result_en, reg_en, log_op, log_sel2, log_sel1, mul_op,
                   mul_sel2, mul_sel1, alu_op, alu_sel2, alu_sel1};
  assign status = {op_ready, busy, done_next};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] mkw(
    input logic [3:0] as1, as2, input logic aop,
    input logic [3:0] ms1, ms2, input logic mop,
    input logic [3:0] ls1, ls2, input logic [1:0] lop,
    input logic [15:0] ren, input logic res, input logic last);
    return {last, res, ren, lop, ls2, ls1, mop, ms2, ms1, aop, as2, as1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [45:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!op_ready && k < 40) begin
      tick();
      k++;
    end
    check(tag, {63'd0, op_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
`ifdef SCHED_STALL_EN
    stall = 1'b0;
`endif
    w[0] = mkw(4'd0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'd0, 16'h0004, 1'b0, 1'b0);
    w[1] = mkw(4'd2, 4'd3, 1'b1, 4'd4, 4'd5, 1'b1, 4'd6, 4'd7, 2'd2, 16'h0010, 1'b1, 1'b0);
    w[2] = mkw(4'd8, 4'd9, 1'b0, 4'd10, 4'd11, 1'b0, 4'd12, 4'd13, 2'd3, 16'h8001, 1'b0, 1'b0);
    w[3] = mkw(4'd15, 4'd14, 1'b1, 4'd13, 4'd12, 1'b1, 4'd11, 4'd10, 2'd1, 16'hFFFF, 1'b1, 1'b1);
    wbad = mkw(4'd1, 4'd1, 1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 4'd1, 2'd3, 16'h1234, 1'b1, 1'b0);
    w0n  = mkw(4'd0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'd1, 16'h0004, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("reset status", 64'(status), 64'b100);
    check("reset fields", 64'(fields), 64'd0);
    check("reset cfg_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;
    tick();

    // four-word run, rejected write at addr 1 mid-run
    for (int i = 0; i < 4; i++) wr(4'(i), w[i]);
    start = 1'b1; tick(); start = 1'b0;
    check("run1 c1 status", 64'(status), 64'b010);
    check("run1 c1 word0", 64'(fields), 64'(w[0][44:0]));
    check("run1 c1 alu_sel2", 64'(alu_sel2), 64'd1);
    check("run1 c1 reg_en2", 64'(reg_en[2]), 64'd1);
    tick();
    check("run1 c2 word1", 64'(fields), 64'(w[1][44:0]));
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = wbad;
    tick(); cfg_we = 1'b0;
    check("run1 c3 cfg_err", 64'(cfg_err), 64'd1);
    check("run1 c3 word2", 64'(fields), 64'(w[2][44:0]));
    tick();
    check("run1 c4 cfg_err", 64'(cfg_err), 64'd0);
    check("run1 c4 word3", 64'(fields), 64'(w[3][44:0]));
    check("run1 c4 status", 64'(status), 64'b010);
    tick();
    check("run1 c5 done", 64'(status), 64'b011);
    check("run1 c5 fields", 64'(fields), 64'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    check("run1 c6 idle", 64'(status), 64'b100);
    check("run1 c6 fields", 64'(fields), 64'd0);

    start = 1'b1; tick(); start = 1'b0;
    check("run2 c1 word0", 64'(fields), 64'(w[0][44:0]));
    tick();
    check("run2 c2 word1 kept", 64'(fields), 64'(w[1][44:0]));
    wait_idle("run2 idle");

    // write word 0 and start in the same idle cycle
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = w0n; start = 1'b1;
    tick(); cfg_we = 1'b0; start = 1'b0;
    check("wrstart c1 word", 64'(fields), 64'(w0n[44:0]));
    check("wrstart c1 log_op", 64'(log_op), 64'd1);
    wait_idle("wrstart idle");

    // asynchronous reset mid-run
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("rstrun c2 word1", 64'(fields), 64'(w[1][44:0]));
    rst = 1'b1;
    #1;
    check("rstrun status", 64'(status), 64'b100);
    check("rstrun fields", 64'(fields), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("zero c%0d status", c), 64'(status), 64'b010);
      check($sformatf("zero c%0d fields", c), 64'(fields), 64'd0);
      tick();
    end
    check("zero c17 done", 64'(status), 64'b011);
    tick();
    check("zero c18 idle", 64'(status), 64'b100);

`ifdef SCHED_STALL_EN
    for (int i = 0; i < 4; i++) wr(4'(i), w[i]);
    start = 1'b1; tick(); start = 1'b0;
    check("stall c1 word0", 64'(fields), 64'(w[0][44:0]));
    tick();
    stall = 1'b1;
    #1;
    for (int c = 2; c <= 4; c++) begin
      check($sformatf("stall c%0d masked", c), 64'(fields), 64'(w[1][27:0]));
      check($sformatf("stall c%0d status", c), 64'(status), 64'b010);
      tick();
    end
    stall = 1'b0;
    #1;
    check("stall c5 word1", 64'(fields), 64'(w[1][44:0]));
    tick();
    check("stall c6 word2", 64'(fields), 64'(w[2][44:0]));
    tick();
    check("stall c7 word3", 64'(fields), 64'(w[3][44:0]));
    tick();
    check("stall c8 done", 64'(status), 64'b011);
    tick();
    check("stall c9 idle", 64'(status), 64'b100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
